// File: rtl/ram_stream_pkg.sv
// rtl/ram_stream_pkg.sv - shared constants and width helpers for the streaming single-port RAM
package ram_stream_pkg;

  // Byte address width seen on the bus port.
  localparam int unsigned AddrWidth = 32;

  // Bytes per word.
  function automatic int unsigned nb_of(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Number of byte-offset bits stripped from the address to form the word index.
  function automatic int unsigned off_w_of(input int unsigned data_width);
    return (data_width <= 8) ? 0 : $clog2(data_width / 8);
  endfunction

  // Width of the word index into the array; at least one bit.
  function automatic int unsigned idx_w_of(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Width of a counter able to hold the values 0..n inclusive.
  function automatic int unsigned cnt_w_of(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Only one or two cycles of read latency are implemented.
  function automatic bit read_latency_legal(input int unsigned rl);
    return (rl == 1) || (rl == 2);
  endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// rtl/ram_rsp_fifo.sv - fall-through response FIFO with full/empty/count status
module ram_rsp_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [Width-1:0]             data_i,
  input  logic                         pop_i,
  output logic                         valid_o,
  output logic [Width-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_write, do_read;

  // Pointers wrap explicitly so Depth need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Status, fall-through head selection and next-state pointer/count logic.
  always_comb begin
    empty_o  = (count_q == '0);
    full_o   = (count_q == CntW'(Depth));
    // An empty FIFO presents the incoming word directly on its output.
    valid_o  = !empty_o || push_i;
    data_o   = empty_o ? data_i : mem_q[rd_ptr_q];
    do_read  = pop_i && !empty_o;
    // A word that is pushed and popped while empty bypasses storage entirely.
    do_write = push_i && !(empty_o && pop_i);
    wr_ptr_d = do_write ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_read ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_write && !do_read) begin
      count_d = count_q + CntW'(1);
    end else if (!do_write && do_read) begin
      count_d = count_q - CntW'(1);
    end
  end

  assign count_o = count_q;

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since occupancy gates the output.
  always_ff @(posedge clk_i) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  a_no_push_full : assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o))
    else $error("ram_rsp_fifo: push while full");

  a_no_pop_empty : assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && !valid_o))
    else $error("ram_rsp_fifo: pop while empty");

endmodule

// File: rtl/ram_1p_stream.sv
// rtl/ram_1p_stream.sv - single-port RAM with credit-based grant, read pipeline and response FIFO
module ram_1p_stream
  import ram_stream_pkg::*;
#(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned Depth        = 128,
  parameter int unsigned ReadLatency  = 1,
  parameter int unsigned RspFifoDepth = 2,
  parameter string       MemInitFile  = ""
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic                   we_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [31:0]            addr_i,
  input  logic [DataWidth-1:0]   wdata_i,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   rerr_o
);

  localparam int          NB   = int'(nb_of(DataWidth));
  localparam int unsigned OffW = off_w_of(DataWidth);
  localparam int unsigned IdxW = idx_w_of(Depth);
  localparam int unsigned CntW = cnt_w_of(RspFifoDepth);
  localparam logic [AddrWidth-1:0] OffMask = AddrWidth'(NB - 1);

  localparam bit ParamsOk = read_latency_legal(ReadLatency) && (DataWidth > 0) &&
                            (DataWidth % 8 == 0) && (Depth >= 2) &&
                            (RspFifoDepth >= ReadLatency);

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 err;
  } rsp_t;

  localparam int unsigned RspW = $bits(rsp_t);

  logic [DataWidth-1:0] mem_q [Depth];

  logic [AddrWidth-1:0] word_idx;
  logic [IdxW-1:0]      idx;
  logic                 addr_err;
  logic                 accept;
  logic                 pop;

  logic                 s1_valid_q, s1_valid_d;
  rsp_t                 s1_q, s1_d;
  logic                 last_valid;
  rsp_t                 last_rsp;

  logic [CntW-1:0]      cnt_q, cnt_d;

  logic                 fifo_valid;
  logic [RspW-1:0]      fifo_data;
  rsp_t                 head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CntW-1:0]      fifo_count;

  // Address decode: misaligned or out-of-range words are errors, and errors never touch the array.
  always_comb begin
    word_idx = addr_i >> OffW;
    addr_err = ((addr_i & OffMask) != '0) || (word_idx >= AddrWidth'(Depth));
    idx      = addr_err ? '0 : word_idx[IdxW-1:0];
  end

  // Credit: outstanding responses (pipeline plus FIFO) never exceed the FIFO depth.
  assign gnt_o  = !rst_i && (cnt_q < CntW'(RspFifoDepth));
  assign accept = req_i && gnt_o;
  assign pop    = rvalid_o && rready_i;

  // Outstanding-count next state; a simultaneous accept and pop cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!accept && pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Outstanding-count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Byte-enabled array write in the accept cycle; erroneous writes are dropped.
  always_ff @(posedge clk_i) begin
    if (accept && we_i && !addr_err) begin
      for (int i = 0; i < NB; i++) begin
        if (be_i[i]) begin
          mem_q[idx][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // First pipeline stage contents: array read data for good reads, zero for writes and errors.
  always_comb begin
    s1_valid_d = accept;
    s1_d       = '0;
    s1_d.err   = accept && addr_err;
    if (accept && !we_i && !addr_err) begin
      s1_d.rdata = mem_q[idx];
    end
  end

  // First pipeline stage register; it never stalls because credits reserve FIFO space.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
    end
  end

  if (ReadLatency == 2) begin : g_rl2
    logic s2_valid_q;
    rsp_t s2_q;

    // Extra output register stage for the two-cycle latency configuration.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        s2_valid_q <= 1'b0;
        s2_q       <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_q       <= s1_q;
      end
    end

    assign last_valid = s2_valid_q;
    assign last_rsp   = s2_q;
  end else begin : g_rl1
    assign last_valid = s1_valid_q;
    assign last_rsp   = s1_q;
  end

  ram_rsp_fifo #(
    .Width (RspW),
    .Depth (RspFifoDepth)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (last_valid),
    .data_i  (last_rsp),
    .pop_i   (pop),
    .valid_o (fifo_valid),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Response outputs are forced to zero whenever no response is presented, including during reset.
  always_comb begin
    head     = rsp_t'(fifo_data);
    rvalid_o = !rst_i && fifo_valid;
    rdata_o  = rvalid_o ? head.rdata : '0;
    rerr_o   = rvalid_o ? head.err : 1'b0;
  end

  a_params_legal : assert property (@(posedge clk_i) ParamsOk)
    else $error("ram_1p_stream: illegal parameter combination");

  a_credit_covers_fifo : assert property (@(posedge clk_i) disable iff (rst_i)
                                          (fifo_count <= cnt_q) && !(fifo_full && last_valid))
    else $error("ram_1p_stream: response FIFO occupancy exceeds credit");

  a_idle_when_drained : assert property (@(posedge clk_i) disable iff (rst_i)
                                         (fifo_empty && !last_valid) |-> !rvalid_o)
    else $error("ram_1p_stream: response presented with nothing queued");

endmodule
